vec_mem_stage: RTL and testbench
================================

// Module: vec_mem_stage
// PURPOSE
//   Parametrised vector/scalar memory stage with built-in MEM/WB pipeline register for the encryption
//   processor. Accepts one op per handshake, runs a vector access as BEATS back-to-back port beats
//   over a narrow memory port, assembles read data, then presents result + EX sideband to writeback.
//   Stalls upstream via ready_o while busy; non-memory ops pass through in one cycle.
// PARAMETERS
//   REGI_BITS   4   scalar register-index width
//   VECT_BITS   2   vector register-index width
//   ELEM_SIZE   8   bits per element
//   VECT_SIZE   8   elements per vector; data bus VW = ELEM_SIZE*VECT_SIZE
//   PORT_LANES  2   elements per memory word/beat; must divide VECT_SIZE; PW = ELEM_SIZE*PORT_LANES
//   MEMO_LINES  64  memory depth in words; localparam AB = $clog2(MEMO_LINES); BEATS = VECT_SIZE/PORT_LANES
// PORTS
//   clk_i            in   1    clock, all state on rising edge
//   rst_i            in   1    asynchronous, active-low reset
//   valid_i          in   1    op present; accepted on edge with valid_i & ready_o
//   ready_o          out  1    1 only in IDLE
//   isVector_i       in   1    1: BEATS-beat vector access; 0: one-word scalar access
//   flagMemRead_i    in   1    load
//   flagMemWrite_i   in   1    store (wins if both set)
//   addr_i           in   AB   base word address
//   wdata_i          in   VW   store data; scalar uses [PW-1:0]
//   enableReg_i, enableJump_i, flagEnd_i, flagNop_i, writeResultInt_i, writeResultV_i  in 1 each  sideband
//   jumpAddress_i    in   10   sideband;  intRegDest_i in REGI_BITS;  vecRegDest_i in VECT_BITS
//   valid_o          out  1    one-cycle pulse: result/sideband valid
//   rdata_o          out  VW   load data; scalar zero-extended from PW; 0 for store/non-mem
//   *_o sideband     out  as inputs   registered copy of accepted op's sideband, held until next valid_o
//   fault_o          out  1    bounds fault, qualifies valid_o (tied 0 without MEM_BOUNDS_CHECK_EN)
// BEHAVIOUR
//   - Reset (async, any time incl. mid-op): state IDLE, beat counter 0, ready_o=1, valid_o=0, rdata_o=0,
//     fault_o=0, all sideband outputs 0. Memory contents not reset; in-flight store beats already written stay.
//   - FSM: IDLE -> BUSY on accept (op, addr, wdata, sideband latched at accept edge E0).
//     N = BEATS if isVector & (read|write), 1 otherwise. Beat k (0..N-1) accesses word (addr+k) mod MEMO_LINES
//     at edge E(k+1): store writes wdata[k*PW +: PW]; load captures word into assembly reg slice k.
//     At edge E_N: BUSY -> IDLE, valid_o=1 and outputs loaded; valid_o drops at E(N+1).
//   - Latency: valid_o high in cycle after E_N (N cycles). Throughput: next accept earliest at E(N+1).
//   - valid_i while ready_o=0 ignored; upstream must hold op until accepted.
//   - Read+write both set: treated as store, rdata_o=0. Neither set: no memory access, N=1, rdata_o=0.
//   - Load after store to same word across ops returns stored data (store completes before next accept).
//   - Address arithmetic modulo MEMO_LINES (AB bits, wrap 63->0 at default).
// CONFIGURATION
//   MEM_BOUNDS_CHECK_EN defined: at accept, if addr_i+N-1 >= MEMO_LINES, op still takes N cycles but no word
//     is written, rdata_o=0, fault_o=1 with valid_o. Undefined: wrap-around as above, fault_o constant 0.
// STRUCTURE
//   - vec_mem_pkg: FSM state enum (IDLE, BUSY), beat-count helper function, sideband packed-struct layout
//     parametrised by REGI_BITS/VECT_BITS defaults.
//   - Sub-module vec_mem_bank: MEMO_LINES x PW array, sync write, sync read into caller's register.
// TESTING  (defaults: PW=16, BEATS=4)
//   1 reset: rst_i low during beat 2 of vector load -> immediately ready_o=1, valid_o=0, all outputs 0.
//   2 vector store addr 4 wdata 64'h0807060504030201, then vector load addr 4 -> ready_o low 4 cycles each,
//     single valid_o pulse each, load rdata_o=64'h0807060504030201.
//   3 scalar store addr 10 wdata 16'hBEEF, scalar load addr 10 -> 1-cycle latency, rdata_o=64'h000000000000BEEF.
//   4 non-mem op jumpAddress 10'h155 intRegDest 5 flagEnd 1 -> valid_o next cycle, sideband echoed, rdata_o 0.
//   5 vector store addr 62: without EN words 62,63,0,1 written; with EN fault_o=1, memory unchanged.
//   6 valid_i held high across two vector ops -> 2nd accepted at E5, 2nd valid_o after E9.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// ---------------------------------------------------------------------------
// vec_mem_pkg
//   Shared types and helpers for the vector/scalar memory stage.
//   - state_t      : two-state control FSM encoding (IDLE, BUSY)
//   - sb_ctrl_t    : width-independent part of the EX->WB sideband bundle
//                    (register-destination fields follow the module's
//                    REGI_BITS/VECT_BITS parameters and live beside it)
//   - beat_count() : number of port beats an accepted op occupies
//   Optional build macro used by the stage: MEM_BOUNDS_CHECK_EN
// ---------------------------------------------------------------------------
package vec_mem_pkg;

  localparam int REGI_BITS_DEF = 4;
  localparam int VECT_BITS_DEF = 2;
  localparam int JUMP_BITS     = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic                 enable_reg;
    logic                 enable_jump;
    logic                 flag_end;
    logic                 flag_nop;
    logic                 write_result_int;
    logic                 write_result_v;
    logic [JUMP_BITS-1:0] jump_address;
  } sb_ctrl_t;

  // Vector memory ops stream the whole vector; everything else is one beat.
  function automatic int beat_count(input logic is_vec, input logic is_mem,
                                    input int beats);
    return (is_vec && is_mem) ? beats : 1;
  endfunction

endpackage

// File: rtl/vec_mem_bank.sv
// ---------------------------------------------------------------------------
// vec_mem_bank
//   DEPTH x PW single-clock memory, synchronous write, registered read.
//   Contents are not reset so the array maps onto block RAM.
//   Ports:
//     clk_i    in  1   clock
//     we_i     in  1   write enable
//     waddr_i  in  AB  write word address
//     wdata_i  in  PW  write data
//     re_i     in  1   read enable (updates rdata_o on the edge)
//     raddr_i  in  AB  read word address
//     rdata_o  out PW  registered read data
// ---------------------------------------------------------------------------
module vec_mem_bank #(
  parameter int PW    = 16,
  parameter int DEPTH = 64,
  localparam int AB   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AB-1:0] waddr_i,
  input  logic [PW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AB-1:0] raddr_i,
  output logic [PW-1:0] rdata_o
);

  logic [PW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      r_rdata <= r_mem[raddr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/vec_mem_stage.sv
// ---------------------------------------------------------------------------
// vec_mem_stage
//   Vector/scalar memory stage with its MEM/WB register. One op is accepted
//   per valid_i & ready_o handshake; vector loads/stores run BEATS beats over
//   a PW-wide port, scalar and non-memory ops take one cycle. The result and
//   the latched sideband are presented with a one-cycle valid_o pulse.
//   Optional macro: MEM_BOUNDS_CHECK_EN -- flag ops whose last word lies past
//   MEMO_LINES-1 with fault_o instead of wrapping (no writes, rdata_o 0).
//   Ports:
//     clk_i, rst_i (async, active low)
//     valid_i / ready_o                 upstream handshake (ready only in IDLE)
//     isVector_i, flagMemRead_i, flagMemWrite_i, addr_i[AB], wdata_i[VW]
//     enableReg_i ... vecRegDest_i      sideband, echoed on *_o
//     valid_o, rdata_o[VW], fault_o     writeback result
// ---------------------------------------------------------------------------
module vec_mem_stage
  import vec_mem_pkg::*;
#(
  parameter int REGI_BITS  = REGI_BITS_DEF,
  parameter int VECT_BITS  = VECT_BITS_DEF,
  parameter int ELEM_SIZE  = 8,
  parameter int VECT_SIZE  = 8,
  parameter int PORT_LANES = 2,
  parameter int MEMO_LINES = 64,
  localparam int VW = ELEM_SIZE * VECT_SIZE,
  localparam int PW = ELEM_SIZE * PORT_LANES,
  localparam int AB = $clog2(MEMO_LINES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 isVector_i,
  input  logic                 flagMemRead_i,
  input  logic                 flagMemWrite_i,
  input  logic [AB-1:0]        addr_i,
  input  logic [VW-1:0]        wdata_i,
  input  logic                 enableReg_i,
  input  logic                 enableJump_i,
  input  logic                 flagEnd_i,
  input  logic                 flagNop_i,
  input  logic                 writeResultInt_i,
  input  logic                 writeResultV_i,
  input  logic [9:0]           jumpAddress_i,
  input  logic [REGI_BITS-1:0] intRegDest_i,
  input  logic [VECT_BITS-1:0] vecRegDest_i,
  output logic                 valid_o,
  output logic [VW-1:0]        rdata_o,
  output logic                 enableReg_o,
  output logic                 enableJump_o,
  output logic                 flagEnd_o,
  output logic                 flagNop_o,
  output logic                 writeResultInt_o,
  output logic                 writeResultV_o,
  output logic [9:0]           jumpAddress_o,
  output logic [REGI_BITS-1:0] intRegDest_o,
  output logic [VECT_BITS-1:0] vecRegDest_o,
  output logic                 fault_o
);

  localparam int BEATS = VECT_SIZE / PORT_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Word address arithmetic wraps modulo MEMO_LINES (also for non-pow2 depth).
  function automatic logic [AB-1:0] wrap_add(input logic [AB-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= MEMO_LINES) s = s - MEMO_LINES;
    return AB'(s);
  endfunction

  // Op latched at accept
  state_t                 r_state;
  logic [BW-1:0]          r_beat;
  logic [BW-1:0]          r_last;
  logic [AB-1:0]          r_addr;
  logic [VW-1:0]          r_wdata;
  logic [VW-1:0]          r_asm;
  logic                   r_is_load;
  logic                   r_is_store;
  logic                   r_oob;
  sb_ctrl_t               r_ctrl;
  logic [REGI_BITS-1:0]   r_int_dest;
  logic [VECT_BITS-1:0]   r_vec_dest;

  // MEM/WB output register
  logic                   r_valid_o;
  logic [VW-1:0]          r_rdata_o;
  logic                   r_fault_o;
  sb_ctrl_t               r_ctrl_o;
  logic [REGI_BITS-1:0]   r_int_dest_o;
  logic [VECT_BITS-1:0]   r_vec_dest_o;

  logic                   w_idle;
  logic                   w_busy;
  logic                   w_accept;
  logic                   w_in_mem;
  int                     w_in_n;
  logic                   w_in_oob;
  logic                   w_beat_last;
  logic [AB-1:0]          w_wr_addr;
  logic [AB-1:0]          w_rd_addr;
  logic                   w_we;
  logic                   w_re;
  logic [PW-1:0]          w_wr_data;
  logic [PW-1:0]          w_bank_rdata;
  logic [PW-1:0]          w_wslice [BEATS];
  logic [VW-1:0]          w_asm_next;
  sb_ctrl_t               w_in_ctrl;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_busy   = (r_state == ST_BUSY);
  assign w_accept = valid_i & w_idle;
  assign w_in_mem = flagMemRead_i | flagMemWrite_i;
  assign w_in_n   = beat_count(isVector_i, w_in_mem, BEATS);

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_in_oob = w_in_mem && ((int'(addr_i) + w_in_n - 1) >= MEMO_LINES);
`else
  assign w_in_oob = 1'b0;
`endif

  assign w_in_ctrl = '{enable_reg:       enableReg_i,
                       enable_jump:      enableJump_i,
                       flag_end:         flagEnd_i,
                       flag_nop:         flagNop_i,
                       write_result_int: writeResultInt_i,
                       write_result_v:   writeResultV_i,
                       jump_address:     jumpAddress_i};

  assign w_beat_last = (r_beat == r_last);
  assign w_wr_addr   = wrap_add(r_addr, int'(r_beat));
  assign w_we        = w_busy & r_is_store & ~r_oob;

  // Reads are issued one beat ahead (the accept edge fetches word 0) so that
  // the registered bank output already holds word k at the edge of beat k.
  assign w_rd_addr = w_busy ? wrap_add(r_addr, int'(r_beat) + 1) : addr_i;
  assign w_re      = w_accept | w_busy;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
      assign w_wslice[gi] = r_wdata[gi*PW +: PW];
      assign w_asm_next[gi*PW +: PW] = (r_is_load && (r_beat == BW'(gi)))
                                       ? w_bank_rdata : r_asm[gi*PW +: PW];
    end
  endgenerate

  assign w_wr_data = w_wslice[r_beat];

  vec_mem_bank #(
    .PW    (PW),
    .DEPTH (MEMO_LINES)
  ) u_bank (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .waddr_i (w_wr_addr),
    .wdata_i (w_wr_data),
    .re_i    (w_re),
    .raddr_i (w_rd_addr),
    .rdata_o (w_bank_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_last       <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_asm        <= '0;
      r_is_load    <= 1'b0;
      r_is_store   <= 1'b0;
      r_oob        <= 1'b0;
      r_ctrl       <= '0;
      r_int_dest   <= '0;
      r_vec_dest   <= '0;
      r_valid_o    <= 1'b0;
      r_rdata_o    <= '0;
      r_fault_o    <= 1'b0;
      r_ctrl_o     <= '0;
      r_int_dest_o <= '0;
      r_vec_dest_o <= '0;
    end else begin
      r_valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            r_state    <= ST_BUSY;
            r_beat     <= '0;
            r_last     <= BW'(w_in_n - 1);
            r_addr     <= addr_i;
            r_wdata    <= wdata_i;
            r_asm      <= '0;
            // A store wins when both flags are set.
            r_is_store <= flagMemWrite_i;
            r_is_load  <= flagMemRead_i & ~flagMemWrite_i;
            r_oob      <= w_in_oob;
            r_ctrl     <= w_in_ctrl;
            r_int_dest <= intRegDest_i;
            r_vec_dest <= vecRegDest_i;
          end
        end
        ST_BUSY: begin
          r_asm <= w_asm_next;
          if (w_beat_last) begin
            r_state      <= ST_IDLE;
            r_valid_o    <= 1'b1;
            r_rdata_o    <= (r_is_load & ~r_oob) ? w_asm_next : '0;
            r_fault_o    <= r_oob;
            r_ctrl_o     <= r_ctrl;
            r_int_dest_o <= r_int_dest;
            r_vec_dest_o <= r_vec_dest;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o          = w_idle;
  assign valid_o          = r_valid_o;
  assign rdata_o          = r_rdata_o;
  assign fault_o          = r_fault_o;
  assign enableReg_o      = r_ctrl_o.enable_reg;
  assign enableJump_o     = r_ctrl_o.enable_jump;
  assign flagEnd_o        = r_ctrl_o.flag_end;
  assign flagNop_o        = r_ctrl_o.flag_nop;
  assign writeResultInt_o = r_ctrl_o.write_result_int;
  assign writeResultV_o   = r_ctrl_o.write_result_v;
  assign jumpAddress_o    = r_ctrl_o.jump_address;
  assign intRegDest_o     = r_int_dest_o;
  assign vecRegDest_o     = r_vec_dest_o;

endmodule

// File: tb/tb_vec_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_stage
//   Scoreboard bench for vec_mem_stage at default parameters (PW=16, BEATS=4).
//   Honours MEM_BOUNDS_CHECK_EN when defined for the build.
// ---------------------------------------------------------------------------
module tb_vec_mem_stage;

  localparam int VW = 64;
  localparam int PW = 16;
  localparam int ML = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        isVector_i = 1'b0;
  logic        flagMemRead_i = 1'b0;
  logic        flagMemWrite_i = 1'b0;
  logic [5:0]  addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic        enableReg_i = 1'b0;
  logic        enableJump_i = 1'b0;
  logic        flagEnd_i = 1'b0;
  logic        flagNop_i = 1'b0;
  logic        writeResultInt_i = 1'b0;
  logic        writeResultV_i = 1'b0;
  logic [9:0]  jumpAddress_i = '0;
  logic [3:0]  intRegDest_i = '0;
  logic [1:0]  vecRegDest_i = '0;
  logic        valid_o;
  logic [63:0] rdata_o;
  logic        enableReg_o, enableJump_o, flagEnd_o, flagNop_o;
  logic        writeResultInt_o, writeResultV_o;
  logic [9:0]  jumpAddress_o;
  logic [3:0]  intRegDest_o;
  logic [1:0]  vecRegDest_o;
  logic        fault_o;

  vec_mem_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .isVector_i       (isVector_i),
    .flagMemRead_i    (flagMemRead_i),
    .flagMemWrite_i   (flagMemWrite_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .enableReg_i      (enableReg_i),
    .enableJump_i     (enableJump_i),
    .flagEnd_i        (flagEnd_i),
    .flagNop_i        (flagNop_i),
    .writeResultInt_i (writeResultInt_i),
    .writeResultV_i   (writeResultV_i),
    .jumpAddress_i    (jumpAddress_i),
    .intRegDest_i     (intRegDest_i),
    .vecRegDest_i     (vecRegDest_i),
    .valid_o          (valid_o),
    .rdata_o          (rdata_o),
    .enableReg_o      (enableReg_o),
    .enableJump_o     (enableJump_o),
    .flagEnd_o        (flagEnd_o),
    .flagNop_o        (flagNop_o),
    .writeResultInt_o (writeResultInt_o),
    .writeResultV_o   (writeResultV_o),
    .jumpAddress_o    (jumpAddress_o),
    .intRegDest_o     (intRegDest_o),
    .vecRegDest_o     (vecRegDest_o),
    .fault_o          (fault_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic [21:0] sb;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem_m [ML];
  int          n_vec  = 0;
  int          n_miss = 0;

  logic [21:0] w_sb_obs;
  assign w_sb_obs = {enableReg_o, enableJump_o, flagEnd_o, flagNop_o,
                     writeResultInt_o, writeResultV_o, jumpAddress_o,
                     intRegDest_o, vecRegDest_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op, wait for its accept edge, and push the model's result.
  task automatic send(input string tag, input logic isv, input logic rd, input logic wr,
                      input logic [5:0] addr, input logic [63:0] wd, input logic [21:0] sb,
                      output int acc);
    exp_t        e;
    int          n;
    int          bud;
    logic        oob;
    logic [63:0] r;
    @(negedge clk_i);
    valid_i        = 1'b1;
    isVector_i     = isv;
    flagMemRead_i  = rd;
    flagMemWrite_i = wr;
    addr_i         = addr;
    wdata_i        = wd;
    {enableReg_i, enableJump_i, flagEnd_i, flagNop_i, writeResultInt_i,
     writeResultV_i, jumpAddress_i, intRegDest_i, vecRegDest_i} = sb;
    bud = 0;
    while (!ready_o && bud < 100) begin
      @(negedge clk_i);
      bud++;
    end
    if (!ready_o) begin
      check({tag, "_accept_timeout"}, 64'd0, 64'd1);
      acc = -1;
      return;
    end
    n   = (isv && (rd || wr)) ? 4 : 1;
    acc = cyc + 1;
    oob = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
    oob = (rd || wr) && ((int'(addr) + n - 1) >= ML);
`endif
    r = '0;
    if (wr) begin
      if (!oob) for (int k = 0; k < n; k++) mem_m[(int'(addr) + k) % ML] = wd[k*PW +: PW];
    end else if (rd && !oob) begin
      for (int k = 0; k < n; k++) r[k*PW +: PW] = mem_m[(int'(addr) + k) % ML];
    end
    e.tag   = tag;
    e.rdata = r;
    e.sb    = sb;
    e.fault = oob;
    e.cyc   = acc + n;
    sb_q.push_back(e);
    @(posedge clk_i);
  endtask

  // Drop valid_i and count busy cycles until ready_o returns.
  task automatic finish_op(input string tag, input int exp_n);
    int cnt;
    cnt = 0;
    @(negedge clk_i);
    valid_i = 1'b0;
    while (!ready_o && cnt < 50) begin
      cnt++;
      @(negedge clk_i);
    end
    check({tag, "_busy"}, 64'(cnt), 64'(exp_n));
  endtask

  always @(negedge clk_i) begin : mon
    exp_t e;
    if (rst_i && valid_o) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        $display("txn %s rdata=%h sb=%h fault=%0d cyc=%0d", e.tag, rdata_o, w_sb_obs, fault_o, cyc);
        check({e.tag, "_rdata"}, rdata_o, e.rdata);
        check({e.tag, "_sb"}, 64'(w_sb_obs), 64'(e.sb));
        check({e.tag, "_fault"}, 64'(fault_o), 64'(e.fault));
        check({e.tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_valid"}, 64'(valid_o), 64'd0);
    check({tag, "_rdata"}, rdata_o, 64'd0);
    check({tag, "_sb"}, 64'(w_sb_obs), 64'd0);
    check({tag, "_fault"}, 64'(fault_o), 64'd0);
  endtask

  initial begin
    int a1, a2, bud;
    for (int i = 0; i < ML; i++) mem_m[i] = '0;

    // Power-on reset
    #2 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("por");
    rst_i = 1'b1;

    // Vector store then vector load, addr 4
    send("t2_vst", 1, 0, 1, 6'd4, 64'h0807060504030201, 22'($urandom), a1);
    finish_op("t2_vst", 4);
    send("t2_vld", 1, 1, 0, 6'd4, 64'($urandom), 22'($urandom), a1);
    finish_op("t2_vld", 4);

    // Scalar store uses only the low port word; scalar load is zero-extended
    send("t3_sst", 0, 0, 1, 6'd10, 64'h123456789ABCBEEF, 22'($urandom), a1);
    finish_op("t3_sst", 1);
    send("t3_sld", 0, 1, 0, 6'd10, 64'($urandom), 22'($urandom), a1);
    finish_op("t3_sld", 1);

    // Non-memory ops, scalar and vector flavoured: one cycle, sideband echoed
    send("t4_nop", 0, 0, 0, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF,
         {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h155, 4'd5, 2'd0}, a1);
    finish_op("t4_nop", 1);
    send("t4_nopv", 1, 0, 0, 6'd33, 64'($urandom), 22'($urandom), a1);
    finish_op("t4_nopv", 1);

    // Read+write together behaves as a store
    send("rw_vst", 1, 1, 1, 6'd30, 64'hA1A2_B1B2_C1C2_D1D2, 22'($urandom), a1);
    finish_op("rw_vst", 4);
    send("rw_vld", 1, 1, 0, 6'd30, 64'd0, 22'($urandom), a1);
    finish_op("rw_vld", 4);

    // Leave distinctive sideband/rdata on the outputs before the reset test
    send("t1_pre", 0, 0, 0, 6'd1,  64'd0, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'h3FF, 4'hF, 2'h3}, a1);
    finish_op("t1_pre", 1);
    send("t1_vld", 1, 1, 0, 6'd4, 64'd0, 22'h2AAAAA, a1);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("t1_busy_before_rst", 64'(ready_o), 64'd0);
    #1 rst_i = 1'b0;
    #1 check_reset_outputs("t1_rst");
    sb_q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check_reset_outputs("t1_after");

    // Wrap / bounds at the top of memory
    send("t5_pre62", 0, 0, 1, 6'd62, 64'h0000_0000_0000_A062, 22'($urandom), a1);
    finish_op("t5_pre62", 1);
    send("t5_pre63", 0, 0, 1, 6'd63, 64'h0000_0000_0000_A063, 22'($urandom), a1);
    finish_op("t5_pre63", 1);
    send("t5_pre00", 0, 0, 1, 6'd0, 64'h0000_0000_0000_A000, 22'($urandom), a1);
    finish_op("t5_pre00", 1);
    send("t5_pre01", 0, 0, 1, 6'd1, 64'h0000_0000_0000_A001, 22'($urandom), a1);
    finish_op("t5_pre01", 1);
    send("t5_vst", 1, 0, 1, 6'd62, 64'h4444_3333_2222_1111, 22'($urandom), a1);
    finish_op("t5_vst", 4);
    send("t5_ld62", 0, 1, 0, 6'd62, 64'd0, 22'($urandom), a1);
    finish_op("t5_ld62", 1);
    send("t5_ld63", 0, 1, 0, 6'd63, 64'd0, 22'($urandom), a1);
    finish_op("t5_ld63", 1);
    send("t5_ld00", 0, 1, 0, 6'd0, 64'd0, 22'($urandom), a1);
    finish_op("t5_ld00", 1);
    send("t5_ld01", 0, 1, 0, 6'd1, 64'd0, 22'($urandom), a1);
    finish_op("t5_ld01", 1);
    send("t5_vld", 1, 1, 0, 6'd62, 64'd0, 22'($urandom), a1);
    finish_op("t5_vld", 4);

    // valid_i held across two back-to-back vector ops
    send("t6_vst", 1, 0, 1, 6'd20, 64'h1122_3344_5566_7788, 22'($urandom), a1);
    send("t6_vld", 1, 1, 0, 6'd20, 64'd0, 22'($urandom), a2);
    finish_op("t6_vld", 4);
    check("t6_accept_gap", 64'(a2 - a1), 64'd5);

    // Drain the scoreboard
    bud = 0;
    while (sb_q.size() != 0 && bud < 100) begin
      @(negedge clk_i);
      bud++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    repeat (4) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
